// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the triggered sample capture engine.
package capture_pkg;

    localparam int unsigned CAP_DEPTH  = 512;
    localparam int unsigned CAP_ADDR_W = 9;
    localparam int unsigned CAP_DATA_W = 16;

    typedef logic [2:0] cap_state_t;

    localparam cap_state_t IDLE      = 3'd0;
    localparam cap_state_t PRETRIG   = 3'd1;
    localparam cap_state_t WAIT_TRIG = 3'd2;
    localparam cap_state_t POST      = 3'd3;
    localparam cap_state_t DONE      = 3'd4;

    // States in which incoming samples are written into the ring.
    function automatic logic is_capture_state(input cap_state_t st);
        return (st == PRETRIG) || (st == WAIT_TRIG) || (st == POST);
    endfunction

endpackage

// File: rtl/sample_capture_writer.sv
// Circular pre/post-trigger capture into the FPGA-side port of the sample buffer.
// Reports the trigger address and the oldest sample of the completed window.
module sample_capture_writer
    import capture_pkg::*;
#(
    parameter int unsigned DATA_W = CAP_DATA_W,
    parameter int unsigned ADDR_W = CAP_ADDR_W,
    parameter int unsigned DEPTH  = CAP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic [ADDR_W-1:0] pre_len,
    output logic [ADDR_W-1:0] buf_address,
    output logic [DATA_W-1:0] buf_writedata,
    output logic              buf_write,
    output logic              buf_chipselect,
    output logic [1:0]        buf_byteenable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] trig_addr
);

    // One extra bit so that a full 512-sample post window fits.
    localparam int unsigned CNT_W = ADDR_W + 1;

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;

    logic [ADDR_W-1:0] buf_address_q;
    logic [DATA_W-1:0] buf_writedata_q;
    logic              buf_write_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic [CNT_W-1:0]  post_len;
    logic [CNT_W-1:0]  pre_cnt_inc;
    logic [CNT_W-1:0]  post_cnt_inc;

    assign accept       = in_valid && is_capture_state(state_q);
    assign post_len     = CNT_W'(DEPTH) - CNT_W'(pre_len_q);
    assign pre_cnt_inc  = pre_cnt_q + CNT_W'(1);
    assign post_cnt_inc = post_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        pre_len_d    = pre_len_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        // The write pointer advances even on an abort cycle: that sample is still written.
        wr_ptr_d     = accept ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        pre_len_d  = pre_len;
                        pre_cnt_d  = '0;
                        post_cnt_d = '0;
                        state_d    = (pre_len != '0) ? PRETRIG : WAIT_TRIG;
                    end
                end
                PRETRIG: begin
                    if (accept) begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == CNT_W'(pre_len_q)) begin
                            state_d = WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (accept && trig) begin
                        trig_addr_d  = wr_ptr_q;
                        start_addr_d = wr_ptr_q - pre_len_q;
                        post_cnt_d   = CNT_W'(1);
                        state_d      = (post_len == CNT_W'(1)) ? DONE : POST;
                    end
                end
                POST: begin
                    if (accept) begin
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == post_len) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            pre_len_q       <= '0;
            pre_cnt_q       <= '0;
            post_cnt_q      <= '0;
            trig_addr_q     <= '0;
            start_addr_q    <= '0;
            buf_address_q   <= '0;
            buf_writedata_q <= '0;
            buf_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_len_q    <= pre_len_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            buf_write_q  <= accept;
            if (accept) begin
                buf_address_q   <= wr_ptr_q;
                buf_writedata_q <= in_data;
            end
            // Status flags are derived from the next state so they line up with the last write.
            busy_q <= is_capture_state(state_d);
            done_q <= (state_d == DONE);
        end
    end

    assign buf_address    = buf_address_q;
    assign buf_writedata  = buf_writedata_q;
    assign buf_write      = buf_write_q;
    assign buf_chipselect = buf_write_q;
    assign buf_byteenable = 2'b11;
    assign busy           = busy_q;
    assign done           = done_q;
    assign start_addr     = start_addr_q;
    assign trig_addr      = trig_addr_q;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Randomized self-checking bench for sample_capture_writer with a sample-index reference model.
module tb_sample_capture_writer;

    localparam int D = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        arm;
    logic        abort;
    logic        trig;
    logic [8:0]  pre_len;
    logic [8:0]  buf_address;
    logic [15:0] buf_writedata;
    logic        buf_write;
    logic        buf_chipselect;
    logic [1:0]  buf_byteenable;
    logic        busy;
    logic        done;
    logic [8:0]  start_addr;
    logic [8:0]  trig_addr;

    int errors = 0;
    int checks = 0;
    int exp_ptr = 0;

    logic [15:0] mem [0:D-1];

    sample_capture_writer dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .arm            (arm),
        .abort          (abort),
        .trig           (trig),
        .pre_len        (pre_len),
        .buf_address    (buf_address),
        .buf_writedata  (buf_writedata),
        .buf_write      (buf_write),
        .buf_chipselect (buf_chipselect),
        .buf_byteenable (buf_byteenable),
        .busy           (busy),
        .done           (done),
        .start_addr     (start_addr),
        .trig_addr      (trig_addr)
    );

    always #5 clk = ~clk;

    // Behavioural model of the dual-port buffer's port 2.
    always @(posedge clk) begin
        if (buf_write) mem[buf_address] <= buf_writedata;
    end

    function automatic int wrap(input int x);
        return ((x % D) + D) % D;
    endfunction

    task automatic check_all_zero(input string name);
        checks++;
        if ({buf_address, buf_writedata, buf_write, buf_chipselect, busy, done, start_addr,
             trig_addr} !== '0 || buf_byteenable !== 2'b11) begin
            errors++;
            $display("FAIL %s: addr=%0d data=%h wr=%b cs=%b busy=%b done=%b start=%0d trig=%0d be=%b, required all zero be=11",
                     name, buf_address, buf_writedata, buf_write, buf_chipselect, busy, done,
                     start_addr, trig_addr, buf_byteenable);
        end
    endtask

    task automatic check_no_write(input string name, input logic exp_busy, input logic exp_done);
        checks++;
        if (buf_write !== 1'b0 || buf_chipselect !== 1'b0 || busy !== exp_busy ||
            done !== exp_done) begin
            errors++;
            $display("FAIL %s: wr=%b cs=%b busy=%b done=%b, required wr=0 cs=0 busy=%b done=%b",
                     name, buf_write, buf_chipselect, busy, done, exp_busy, exp_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b1; abort = 1'b0; trig = 1'b1; in_valid = 1'b1;
        in_data = 16'hbeef; pre_len = 9'd3;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0; arm = 1'b0; trig = 1'b0;
        @(negedge clk);
        check_no_write("idle_after_reset", 1'b0, 1'b0);
        in_valid = 1'b0;
        exp_ptr = 0;
    endtask

    // Full capture: sample s lands at ptr0+s; trigger is the first trig sample with index >= pl;
    // the window ends DEPTH-pl samples after (and including) the trigger.
    task automatic capture_run(input int pl, input int period, input int early, input int trig_at,
                               input bit cnt_data, input string name);
        int ptr0, s, cyc, t_idx, last, bad, first_bad;
        bit v, tg, fin;
        logic [15:0] d;
        logic [15:0] sdata [$];
        ptr0 = exp_ptr; s = 0; cyc = 0; t_idx = -1; last = -1; fin = 1'b0;
        arm = 1'b1; pre_len = 9'(pl); in_valid = 1'b0; trig = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_arm: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        end
        while (!fin && cyc < 6000) begin
            v = (cyc % period) == 0;
            tg = 1'b0; d = '0;
            if (v) begin
                d  = cnt_data ? 16'(s) : 16'($urandom);
                tg = (s == trig_at) || (s == early) || (s < pl && $urandom_range(3) == 0);
            end
            in_valid = v; in_data = d; trig = tg;
            arm = ($urandom_range(15) == 0);
            @(negedge clk);
            cyc++;
            checks++;
            if (buf_write !== v || buf_chipselect !== v) begin
                errors++;
                $display("FAIL %s_write: cyc=%0d wr=%b cs=%b, required %b", name, cyc, buf_write,
                         buf_chipselect, v);
            end
            if (v) begin
                checks++;
                if (buf_address !== 9'(wrap(ptr0 + s)) || buf_writedata !== d) begin
                    errors++;
                    $display("FAIL %s_addr_data: sample=%0d addr=%0d data=%h, required addr=%0d data=%h",
                             name, s, buf_address, buf_writedata, wrap(ptr0 + s), d);
                end
                sdata.push_back(d);
                if (t_idx < 0 && s >= pl && tg) begin
                    t_idx = s;
                    last  = s + D - pl - 1;
                end
                if (s == last) fin = 1'b1;
                s++;
            end
            checks++;
            if (done !== fin || busy !== !fin) begin
                errors++;
                $display("FAIL %s_status: cyc=%0d busy=%b done=%b, required busy=%b done=%b", name,
                         cyc, busy, done, !fin, fin);
            end
        end
        arm = 1'b0; in_valid = 1'b0; trig = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout: samples=%0d, required completion within 6000 cycles", name, s);
        end
        checks++;
        if (trig_addr !== 9'(wrap(ptr0 + trig_at))) begin
            errors++;
            $display("FAIL %s_trig_addr: got %0d, required %0d", name, trig_addr,
                     wrap(ptr0 + trig_at));
        end
        checks++;
        if (start_addr !== 9'(wrap(ptr0 + trig_at - pl))) begin
            errors++;
            $display("FAIL %s_start_addr: got %0d, required %0d", name, start_addr,
                     wrap(ptr0 + trig_at - pl));
        end
        exp_ptr = wrap(ptr0 + last + 1);
        checks++;
        if (start_addr !== 9'(exp_ptr)) begin
            errors++;
            $display("FAIL %s_start_vs_ptr: got %0d, required final ptr %0d", name, start_addr,
                     exp_ptr);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; trig = 1'b1; in_data = 16'($urandom);
            @(negedge clk);
            check_no_write({name, "_done_hold"}, 1'b0, 1'b1);
        end
        in_valid = 1'b0; trig = 1'b0;
        if (fin) begin
            bad = 0; first_bad = -1;
            for (int k = 0; k < D; k++) begin
                if (mem[wrap(exp_ptr + k)] !== sdata[last - (D - 1) + k]) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_window: %0d wrong words, first at k=%0d, required 0 wrong", name,
                         bad, first_bad);
            end
        end
    endtask

    // Arm, feed n continuous samples (trigger at tpos if >= 0), then abort.
    task automatic run_abort(input int pl, input int n, input int tpos, input bit abort_valid,
                             input string name);
        int ptr0;
        logic [15:0] d;
        ptr0 = exp_ptr;
        arm = 1'b1; pre_len = 9'(pl); in_valid = 1'b0; trig = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        for (int s = 0; s < n; s++) begin
            d = 16'($urandom);
            in_valid = 1'b1; in_data = d; trig = (s == tpos);
            @(negedge clk);
            checks++;
            if (buf_write !== 1'b1 || buf_address !== 9'(wrap(ptr0 + s)) ||
                buf_writedata !== d || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_feed: s=%0d wr=%b addr=%0d data=%h busy=%b done=%b, required wr=1 addr=%0d data=%h busy=1 done=0",
                         name, s, buf_write, buf_address, buf_writedata, busy, done,
                         wrap(ptr0 + s), d);
            end
        end
        d = 16'($urandom);
        in_valid = abort_valid; in_data = d; trig = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if (buf_write !== abort_valid || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_abort: wr=%b busy=%b done=%b, required wr=%b busy=0 done=0", name,
                     buf_write, busy, done, abort_valid);
        end
        if (abort_valid) begin
            checks++;
            if (buf_address !== 9'(wrap(ptr0 + n)) || buf_writedata !== d) begin
                errors++;
                $display("FAIL %s_abort_sample: addr=%0d data=%h, required addr=%0d data=%h", name,
                         buf_address, buf_writedata, wrap(ptr0 + n), d);
            end
        end
        if (tpos >= 0) begin
            checks++;
            if (trig_addr !== 9'(wrap(ptr0 + tpos))) begin
                errors++;
                $display("FAIL %s_trig_hold: got %0d, required %0d", name, trig_addr,
                         wrap(ptr0 + tpos));
            end
        end
        exp_ptr = wrap(ptr0 + n + int'(abort_valid));
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); trig = 1'b1;
            @(negedge clk);
            check_no_write({name, "_after_abort"}, 1'b0, 1'b0);
        end
        in_valid = 1'b0; trig = 1'b0;
    endtask

    task automatic test_pretrig();
        capture_run(100, 1, -1, 300, 1'b1, "pretrig");
    endtask

    task automatic test_zero_pretrig();
        capture_run(0, 1, -1, 0, 1'b0, "zero_pre");
    endtask

    task automatic test_early_trigger();
        capture_run(50, 1, 10, 60, 1'b0, "early_trig");
    endtask

    task automatic test_sparse_wrap();
        run_abort(0, wrap(500 - exp_ptr), -1, 1'b0, "ptr_prep");
        capture_run(30, 3, 5, 40, 1'b0, "sparse_wrap");
    endtask

    task automatic test_abort_rearm();
        run_abort(10, 60, 20, 1'b1, "abort_post");
        arm = 1'b1; abort = 1'b1; pre_len = 9'd5;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            @(negedge clk);
            check_no_write("arm_abort_same", 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        capture_run(7, 2, 3, 15, 1'b0, "rearm");
    endtask

    task automatic test_reset_mid();
        arm = 1'b1; pre_len = 9'd200;
        @(negedge clk);
        arm = 1'b0;
        for (int s = 0; s < 50; s++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_mid");
        exp_ptr = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); trig = 1'b1;
            @(negedge clk);
            check_no_write("idle_after_reset_mid", 1'b0, 1'b0);
        end
        in_valid = 1'b0; trig = 1'b0;
        capture_run(5, 1, -1, 20, 1'b0, "after_reset");
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        pre_len = '0;
        test_reset();
        test_pretrig();
        test_zero_pretrig();
        test_early_trigger();
        test_sparse_wrap();
        test_abort_rearm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
